// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control-pulse and display bus of the countdown timer.
//                master drives the one-cycle control pulses and reads the
//                display fields; slave (the timer) is the reverse.
//                Pulses : start_stop, clear, plus_sec, minus_sec,
//                         plus_min, minus_min
//                Results: ms_10 (0..99), secs (0..59), mins (0..59),
//                         running, done
//  Revision    : 1.0  initial release
// ============================================================================
interface countdown_timer_if;
    logic       start_stop;
    logic       clear;
    logic       plus_sec;
    logic       minus_sec;
    logic       plus_min;
    logic       minus_min;
    logic [6:0] ms_10;
    logic [5:0] secs;
    logic [5:0] mins;
    logic       running;
    logic       done;

    modport master (
        output start_stop, clear, plus_sec, minus_sec, plus_min, minus_min,
        input  ms_10, secs, mins, running, done
    );

    modport slave (
        input  start_stop, clear, plus_sec, minus_sec, plus_min, minus_min,
        output ms_10, secs, mins, running, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : mm:ss.cc countdown timer. Set-mode pulses load the start
//                value, start_stop runs/pauses, the count steps down one
//                centisecond every TICK_DIV clocks and parks in DONE at zero.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous active-high, clears all state
//                bus   - countdown_timer_if.slave (pulses in, display out)
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int TICK_DIV = 500_000,
    parameter int BW       = $clog2(TICK_DIV)
) (
    input  wire logic            clk,
    input  wire logic            reset,
    countdown_timer_if.slave     bus
);

    localparam logic [1:0] S_SET   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BW-1:0] c_DIV_MAX = BW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_DIV_ONE = BW'(1);

    logic [1:0]    r_state, w_state_nxt;
    logic [6:0]    r_ms,    w_ms_nxt;
    logic [5:0]    r_sec,   w_sec_nxt;
    logic [5:0]    r_min,   w_min_nxt;
    logic [BW-1:0] r_div,   w_div_nxt;
    logic          r_running;
    logic          r_done;

    logic          w_zero;
    logic          w_tick;
    logic [6:0]    w_dec_ms;
    logic [5:0]    w_dec_sec;
    logic [5:0]    w_dec_min;
    logic          w_dec_zero;
    logic [5:0]    w_adj_sec;
    logic [5:0]    w_adj_min;

    // Field adjust with 0..59 wrap; simultaneous +/- cancel out.
    function automatic logic [5:0] f_adj(input logic [5:0] v,
                                         input logic inc, input logic dec);
        logic [5:0] r;
        r = v;
        if (inc && !dec) r = (v == 6'd59) ? 6'd0 : v + 6'd1;
        else if (dec && !inc) r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        return r;
    endfunction

    assign w_zero    = (r_ms == 7'd0) && (r_sec == 6'd0) && (r_min == 6'd0);
    assign w_tick    = (r_div == c_DIV_MAX);
    assign w_adj_sec = f_adj(r_sec, bus.plus_sec, bus.minus_sec);
    assign w_adj_min = f_adj(r_min, bus.plus_min, bus.minus_min);

    // Centisecond borrow chain; RUN never holds zero, so mins cannot underflow.
    assign w_dec_ms   = (r_ms != 7'd0) ? r_ms - 7'd1 : 7'd99;
    assign w_dec_sec  = (r_ms != 7'd0) ? r_sec :
                        ((r_sec != 6'd0) ? r_sec - 6'd1 : 6'd59);
    assign w_dec_min  = ((r_ms != 7'd0) || (r_sec != 6'd0)) ? r_min : r_min - 6'd1;
    assign w_dec_zero = (w_dec_ms == 7'd0) && (w_dec_sec == 6'd0) && (w_dec_min == 6'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_ms_nxt    = r_ms;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_div_nxt   = r_div;

        if (bus.clear) begin
            w_state_nxt = S_SET;
            w_ms_nxt    = 7'd0;
            w_sec_nxt   = 6'd0;
            w_min_nxt   = 6'd0;
            w_div_nxt   = '0;
        end else begin
            case (r_state)
                S_SET: begin
                    w_ms_nxt = 7'd0;
                    if (bus.start_stop) begin
                        if (!w_zero) begin
                            w_state_nxt = S_RUN;
                            w_div_nxt   = '0;
                        end
                    end else begin
                        w_sec_nxt = w_adj_sec;
                        w_min_nxt = w_adj_min;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_ms_nxt  = w_dec_ms;
                        w_sec_nxt = w_dec_sec;
                        w_min_nxt = w_dec_min;
                        w_div_nxt = '0;
                    end else if (!bus.start_stop) begin
                        // The pause edge itself does not advance the divider.
                        w_div_nxt = r_div + c_DIV_ONE;
                    end
                    if (w_tick && w_dec_zero) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.start_stop) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (bus.start_stop) begin
                        if (w_zero) begin
                            w_state_nxt = S_SET;
                            w_div_nxt   = '0;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_sec_nxt = w_adj_sec;
                        w_min_nxt = w_adj_min;
                    end
                end
                default: begin
                    w_ms_nxt  = 7'd0;
                    w_sec_nxt = 6'd0;
                    w_min_nxt = 6'd0;
                    w_div_nxt = '0;
                    if (bus.start_stop) w_state_nxt = S_SET;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_SET;
            r_ms      <= 7'd0;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_div     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ms      <= w_ms_nxt;
            r_sec     <= w_sec_nxt;
            r_min     <= w_min_nxt;
            r_div     <= w_div_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.ms_10   = r_ms;
    assign bus.secs    = r_sec;
    assign bus.mins    = r_min;
    assign bus.running = r_running;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Bench for countdown_timer (TICK_DIV=4). Reference model keeps
//                the remaining time as a single centisecond total.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if bus ();

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 SET, 1 RUN, 2 PAUSE, 3 DONE
    int m_state = 0;
    int m_total = 0;
    int m_phase = 0;

    task automatic m_adjust(input int ps, input int msn, input int pm, input int mm);
        int mi, s, c;
        mi = m_total / 6000;
        s  = (m_total / 100) % 60;
        c  = m_total % 100;
        s  = (s + ps - msn + 60) % 60;
        mi = (mi + pm - mm + 60) % 60;
        m_total = mi * 6000 + s * 100 + c;
    endtask

    task automatic m_step(input logic ss, clr, ps, msn, pm, mm, rst);
        if (rst) begin
            m_state = 0; m_total = 0; m_phase = 0;
        end else if (clr) begin
            m_state = 0; m_total = 0; m_phase = 0;
        end else begin
            case (m_state)
                0: if (ss) begin
                       if (m_total != 0) begin m_state = 1; m_phase = 0; end
                   end else m_adjust(int'(ps), int'(msn), int'(pm), int'(mm));
                1: begin
                       if (m_phase == TD - 1) begin
                           m_total = m_total - 1;
                           m_phase = 0;
                           if (m_total == 0) m_state = 3;
                           else if (ss) m_state = 2;
                       end else if (ss) m_state = 2;
                       else m_phase = m_phase + 1;
                   end
                2: if (ss) begin
                       if (m_total == 0) begin m_state = 0; m_phase = 0; end
                       else m_state = 1;
                   end else m_adjust(int'(ps), int'(msn), int'(pm), int'(mm));
                default: begin
                       m_total = 0; m_phase = 0;
                       if (ss) m_state = 0;
                   end
            endcase
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic ss, clr, ps, msn, pm, mm, rst);
        int em, es, ec, er, ed;
        @(negedge clk);
        bus.start_stop = ss; bus.clear = clr;
        bus.plus_sec = ps; bus.minus_sec = msn;
        bus.plus_min = pm; bus.minus_min = mm;
        reset = rst;
        @(posedge clk);
        m_step(ss, clr, ps, msn, pm, mm, rst);
        #1;
        em = m_total / 6000;
        es = (m_total / 100) % 60;
        ec = m_total % 100;
        er = (m_state == 1) ? 1 : 0;
        ed = (m_state == 3) ? 1 : 0;
        checks++;
        if (int'(bus.mins) != em || int'(bus.secs) != es || int'(bus.ms_10) != ec ||
            int'(bus.running) != er || int'(bus.done) != ed) begin
            errors++;
            $display("FAIL model: got %0d:%0d.%0d run=%0d done=%0d expected %0d:%0d.%0d run=%0d done=%0d at %0t",
                     bus.mins, bus.secs, bus.ms_10, bus.running, bus.done,
                     em, es, ec, er, ed, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_time(input string nm, input int mi, input int s, input int c,
                            input int run, input int dn);
        chk({nm, ".mins"},    int'(bus.mins),    mi);
        chk({nm, ".secs"},    int'(bus.secs),    s);
        chk({nm, ".ms_10"},   int'(bus.ms_10),   c);
        chk({nm, ".running"}, int'(bus.running), run);
        chk({nm, ".done"},    int'(bus.done),    dn);
    endtask

    typedef struct {
        logic ss, clr, ps, msn, pm, mm, rst;
        int   e_min, e_sec, e_ms, e_run, e_done;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // ss clr ps msn pm mm rst | min sec ms run done
        tbl[0]  = '{0,0,0,0,0,0,1,  0, 0,0,0,0};
        tbl[1]  = '{0,0,1,0,0,0,0,  0, 1,0,0,0};
        tbl[2]  = '{0,0,1,0,0,0,0,  0, 2,0,0,0};
        tbl[3]  = '{0,0,1,0,0,0,0,  0, 3,0,0,0};
        tbl[4]  = '{0,0,0,0,1,0,0,  1, 3,0,0,0};
        tbl[5]  = '{0,1,0,0,0,0,0,  0, 0,0,0,0};
        tbl[6]  = '{0,0,0,1,0,0,0,  0,59,0,0,0};
        tbl[7]  = '{0,0,1,1,0,0,0,  0,59,0,0,0};
        tbl[8]  = '{0,0,0,0,1,1,0,  0,59,0,0,0};
        tbl[9]  = '{0,0,0,0,0,1,0, 59,59,0,0,0};
        tbl[10] = '{0,1,0,0,0,0,0,  0, 0,0,0,0};
        tbl[11] = '{1,0,0,0,0,0,0,  0, 0,0,0,0};
        tbl[12] = '{0,0,0,0,0,1,0, 59, 0,0,0,0};
        tbl[13] = '{1,0,1,0,0,0,0, 59, 0,0,1,0};
        tbl[14] = '{0,0,1,0,1,0,0, 59, 0,0,1,0};
        tbl[15] = '{0,0,0,0,0,0,1,  0, 0,0,0,0};

        reset = 1'b1;
        bus.start_stop = 0; bus.clear = 0;
        bus.plus_sec = 0; bus.minus_sec = 0; bus.plus_min = 0; bus.minus_min = 0;

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].ss, tbl[i].clr, tbl[i].ps, tbl[i].msn, tbl[i].pm, tbl[i].mm, tbl[i].rst);
            chk_time($sformatf("tbl%0d", i), tbl[i].e_min, tbl[i].e_sec, tbl[i].e_ms,
                     tbl[i].e_run, tbl[i].e_done);
        end

        // 00:01 down to done, then DONE ignores adjust and start_stop acknowledges
        cyc(0,0,1,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        chk_time("start01", 0, 1, 0, 1, 0);
        idle(4);
        chk_time("first_tick", 0, 0, 99, 1, 0);
        idle(395);
        chk_time("last_before", 0, 0, 1, 1, 0);
        idle(1);
        chk_time("reach_done", 0, 0, 0, 0, 1);
        cyc(0,0,0,0,1,0,0);
        chk_time("done_adj", 0, 0, 0, 0, 1);
        cyc(1,0,0,0,0,0,0);
        chk_time("done_ack", 0, 0, 0, 0, 0);

        // 01:00 full borrow chain
        cyc(0,0,0,0,1,0,0);
        cyc(1,0,0,0,0,0,0);
        idle(3);
        chk_time("borrow_pre", 1, 0, 0, 1, 0);
        idle(1);
        chk_time("borrow", 0, 59, 99, 1, 0);
        cyc(0,0,0,0,0,0,1);

        // pause keeps the partial tick
        cyc(0,0,1,0,0,0,0);
        cyc(0,0,1,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        idle(2);
        cyc(1,0,0,0,0,0,0);
        chk_time("paused", 0, 2, 0, 0, 0);
        idle(20);
        chk_time("frozen", 0, 2, 0, 0, 0);
        cyc(1,0,0,0,0,0,0);
        idle(1);
        chk_time("resume1", 0, 2, 0, 1, 0);
        idle(1);
        chk_time("resume2", 0, 1, 99, 1, 0);
        cyc(1,0,0,0,0,0,0);
        cyc(0,1,0,0,0,0,0);
        chk_time("clr_pause", 0, 0, 0, 0, 0);

        // reset mid-run
        cyc(0,0,1,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        idle(6);
        cyc(0,0,0,0,0,0,1);
        chk_time("rst_run", 0, 0, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(29) == 0), ($urandom_range(399) == 0),
                ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                ($urandom_range(4) == 0), ($urandom_range(7) == 0),
                ($urandom_range(1999) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
